// File: rtl/stream_pkt_tx.sv
// Valid/ready packet transmitter: emits i_len beats of incrementing data from i_start_val.
// Optional inter-beat throttling is enabled by defining STREAM_PKT_TX_THROTTLE_EN.
//
// state | meaning
// IDLE  | waiting for i_start; o_beat_cnt holds last packet's count
// SEND  | a beat is presented on o_data/o_valid until accepted
// DONE  | packet finished; o_done pulses on the following cycle
// GAP   | one-cycle bubble between beats (throttle build only)
module stream_pkt_tx #(
  parameter int DWIDTH = 8,
  parameter int LWIDTH = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_start,
  input  logic [DWIDTH-1:0] i_start_val,
  input  logic [LWIDTH-1:0] i_len,
  input  logic              i_ready,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_valid,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_done,
  output logic [LWIDTH-1:0] o_beat_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
`ifdef STREAM_PKT_TX_THROTTLE_EN
  localparam logic [1:0] ST_GAP  = 2'd3;
`endif

  logic [1:0]        state;
  logic [LWIDTH-1:0] len_q;
  logic              xfer;
  logic              gap_take;

  assign xfer   = o_valid & i_ready;
  assign o_busy = (state != ST_IDLE);

`ifdef STREAM_PKT_TX_THROTTLE_EN
  logic [7:0] lfsr;

  // Fibonacci LFSR, taps 8,6,5,4; free-running from the reset seed
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign gap_take = lfsr[0];
`else
  assign gap_take = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      len_q      <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_last     <= 1'b0;
      o_done     <= 1'b0;
      o_beat_cnt <= '0;
    end else begin
      o_done <= (state == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            o_beat_cnt <= '0;
            len_q      <= i_len;
            if (i_len != '0) begin
              o_data  <= i_start_val;
              o_valid <= 1'b1;
              o_last  <= (i_len == LWIDTH'(1));
              state   <= ST_SEND;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_SEND: begin
          if (xfer) begin
            o_beat_cnt <= o_beat_cnt + LWIDTH'(1);
            if (o_last) begin
              o_valid <= 1'b0;
              o_last  <= 1'b0;
              state   <= ST_DONE;
            end else begin
              o_data <= o_data + DWIDTH'(1);
              // beats accepted after this one is cnt+1; next beat is final when cnt+2 == len
              o_last <= ((o_beat_cnt + LWIDTH'(2)) == len_q);
              if (gap_take) begin
                o_valid <= 1'b0;
`ifdef STREAM_PKT_TX_THROTTLE_EN
                state   <= ST_GAP;
`endif
              end
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
`ifdef STREAM_PKT_TX_THROTTLE_EN
        ST_GAP: begin
          o_valid <= 1'b1;
          state   <= ST_SEND;
        end
`endif
        default: begin
          state   <= ST_IDLE;
          o_valid <= 1'b0;
          o_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_pkt_tx.sv
// Self-checking bench for stream_pkt_tx: queue-based packet model plus directed literal checks
// and randomized start/ready stimulus.
`timescale 1ns/1ps
module tb_stream_pkt_tx;
  localparam int DW = 8;
  localparam int LW = 8;
`ifdef STREAM_PKT_TX_THROTTLE_EN
  localparam bit THR = 1'b1;
`else
  localparam bit THR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          i_start = 1'b0;
  logic [DW-1:0] i_start_val = '0;
  logic [LW-1:0] i_len = '0;
  logic          i_ready = 1'b0;
  logic [DW-1:0] o_data;
  logic          o_valid, o_last, o_busy, o_done;
  logic [LW-1:0] o_beat_cnt;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  stream_pkt_tx #(.DWIDTH(DW), .LWIDTH(LW)) dut (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_start_val(i_start_val),
    .i_len(i_len), .i_ready(i_ready), .o_data(o_data), .o_valid(o_valid),
    .o_last(o_last), .o_busy(o_busy), .o_done(o_done), .o_beat_cnt(o_beat_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: beats still owed by the current packet, plus what the sink has accepted
  typedef struct { logic [DW-1:0] d; logic l; } beat_t;
  beat_t         q[$];
  logic [DW-1:0] rx[$];
  int            phase = 0;      // 0 idle, 1 packet in flight, 2 packet finished
  logic          done_now = 1'b0;
  logic          gap_now = 1'b0;
  logic          gap_next;
  logic [LW-1:0] exp_cnt = '0;
  logic [7:0]    m_lfsr = 8'hA5;
  int            gaps = 0;
  logic          s_valid = 1'b0;
  beat_t         b;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase    = 0;
      q.delete();
      done_now = 1'b0;
      gap_now  = 1'b0;
      exp_cnt  = '0;
      m_lfsr   = 8'hA5;
    end else begin
      done_now = (phase == 2);
      gap_next = 1'b0;
      case (phase)
        0: if (i_start) begin
          exp_cnt = '0;
          if (i_len == '0) phase = 2;
          else begin
            for (int i = 0; i < int'(i_len); i++) begin
              b.d = i_start_val + DW'(i);
              b.l = (i == int'(i_len) - 1);
              q.push_back(b);
            end
            phase = 1;
          end
        end
        1: if (s_valid && i_ready) begin
          rx.push_back(q[0].d);
          void'(q.pop_front());
          exp_cnt++;
          if (q.size() == 0) phase = 2;
          else if (THR && m_lfsr[0]) begin
            gap_next = 1'b1;
            gaps++;
          end
        end
        default: phase = 0;
      endcase
      gap_now = gap_next;
      m_lfsr  = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  always @(negedge clk) begin
    s_valid = o_valid;
    if (rstn) begin
      chk("busy", o_busy, phase != 0);
      chk("done", o_done, done_now);
      chk("beat_cnt", o_beat_cnt, exp_cnt);
      if (phase == 1 && !gap_now) begin
        chk("valid", o_valid, 1);
        chk("data", o_data, q[0].d);
        chk("last", o_last, q[0].l);
      end else begin
        chk("valid_low", o_valid, 0);
      end
    end
  end

  task automatic start_pkt(input logic [DW-1:0] v, input logic [LW-1:0] l);
    @(negedge clk);
    i_start = 1'b1; i_start_val = v; i_len = l;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int limit);
    int k = 0;
    while ((phase != 0 || done_now || o_busy || o_valid) && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_timeout"}, k < limit, 1);
  endtask

  int k;
  int g_obs;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_cnt", o_beat_cnt, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // basic
    rx.delete(); i_ready = 1'b1;
    start_pkt(8'h10, 8'd4);
    chk("basic_first_valid", o_valid, 1);
    chk("basic_first_data", o_data, 8'h10);
    wait_idle("basic", 100);
    chk("basic_n", rx.size(), 4);
    for (int i = 0; i < 4; i++) chk("basic_rx", (i < rx.size()) ? rx[i] : 8'hxx, 8'h10 + 8'(i));
    chk("basic_cnt", o_beat_cnt, 4);

    // backpressure on beat 0x21
    rx.delete();
    start_pkt(8'h20, 8'd3);
    k = 0;
    while (!(o_valid && o_data == 8'h21) && k < 50) begin @(negedge clk); k++; end
    chk("bp_reach_timeout", k < 50, 1);
    i_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_valid", o_valid, 1);
      chk("bp_hold_data", o_data, 8'h21);
    end
    i_ready = 1'b1;
    wait_idle("bp", 100);
    chk("bp_n", rx.size(), 3);
    for (int i = 0; i < 3; i++) chk("bp_rx", (i < rx.size()) ? rx[i] : 8'hxx, 8'h20 + 8'(i));

    // wrap, then zero length
    rx.delete();
    start_pkt(8'hFE, 8'd3);
    wait_idle("wrap", 100);
    chk("wrap_n", rx.size(), 3);
    if (rx.size() == 3) begin
      chk("wrap_rx0", rx[0], 8'hFE);
      chk("wrap_rx1", rx[1], 8'hFF);
      chk("wrap_rx2", rx[2], 8'h00);
    end
    start_pkt(8'h77, 8'd0);
    chk("zero_done_early", o_done, 0);
    chk("zero_busy", o_busy, 1);
    @(negedge clk);
    chk("zero_done", o_done, 1);
    chk("zero_valid", o_valid, 0);
    chk("zero_cnt", o_beat_cnt, 0);
    wait_idle("zero", 20);

    // start while busy ignored; start in the o_done cycle accepted
    rx.delete();
    start_pkt(8'h40, 8'd4);
    i_start = 1'b1; i_start_val = 8'h50; i_len = 8'd2;
    repeat (2) @(negedge clk);
    i_start = 1'b0;
    k = 0;
    while (!o_done && k < 50) begin @(negedge clk); k++; end
    chk("busy_done_timeout", k < 50, 1);
    i_start = 1'b1; i_start_val = 8'h60; i_len = 8'd2;
    @(negedge clk);
    i_start = 1'b0;
    chk("restart_valid", o_valid, 1);
    chk("restart_data", o_data, 8'h60);
    wait_idle("restart", 100);
    chk("restart_n", rx.size(), 6);
    if (rx.size() == 6) begin
      for (int i = 0; i < 4; i++) chk("busy_rx", rx[i], 8'h40 + 8'(i));
      chk("restart_rx0", rx[4], 8'h60);
      chk("restart_rx1", rx[5], 8'h61);
    end

    // reset mid-packet
    rx.delete();
    start_pkt(8'h30, 8'd5);
    k = 0;
    while (rx.size() < 2 && k < 50) begin @(negedge clk); k++; end
    chk("midrst_timeout", k < 50, 1);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_valid", o_valid, 0);
    chk("midrst_data", o_data, 0);
    chk("midrst_last", o_last, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_cnt", o_beat_cnt, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("postrst_valid", o_valid, 0);
    end

`ifdef STREAM_PKT_TX_THROTTLE_EN
    rx.delete(); gaps = 0; g_obs = 0; i_ready = 1'b1;
    start_pkt(8'h80, 8'd16);
    k = 0;
    while ((phase != 0 || done_now) && k < 200) begin
      if (o_busy && !o_valid) g_obs++;
      @(negedge clk);
      k++;
    end
    chk("thr_timeout", k < 200, 1);
    chk("thr_n", rx.size(), 16);
    chk("thr_gap_any", gaps > 0, 1);
    chk("thr_gaps", g_obs - 1, gaps);
`endif

    // maximum length under random backpressure
    rx.delete();
    start_pkt(8'h00, 8'hFF);
    k = 0;
    while ((phase != 0 || done_now) && k < 3000) begin
      i_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      k++;
    end
    chk("max_timeout", k < 3000, 1);
    chk("max_n", rx.size(), 255);
    chk("max_cnt", o_beat_cnt, 8'hFF);

    // random starts, lengths and ready
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      i_ready     = ($urandom_range(0, 3) != 0);
      i_start     = ($urandom_range(0, 5) == 0);
      i_start_val = DW'($urandom);
      i_len       = ($urandom_range(0, 7) == 0) ? '0 : LW'($urandom_range(1, 12));
    end
    @(negedge clk);
    i_start = 1'b0; i_ready = 1'b1;
    wait_idle("rand", 100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stream_pkt_tx.md
Name: stream_pkt_tx

Overview:
- Valid/ready packet transmitter: on a start command, emits a packet of i_len beats of incrementing data, beginning at i_start_val.
- Serves as the producer end of the team's valid/ready streaming interface. Drives pipe_skid_buffer inputs and other stream sinks.
- Honours downstream backpressure beat by beat.
- Reports busy, done and a count of accepted beats.

Parameters:
- DWIDTH, 8, data width of o_data and i_start_val.
- LWIDTH, 8, width of i_len and o_beat_cnt; maximum packet length is 2^LWIDTH-1 beats.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rstn  input  1  asynchronous active-low reset.
- i_start  input  1  start command pulse; sampled only in IDLE.
- i_start_val  input  DWIDTH  data value of first beat; captured with i_start.
- i_len  input  LWIDTH  beats in packet; captured with i_start.
- i_ready  input  1  downstream ready.
- o_data  output  DWIDTH  beat data.
- o_valid  output  1  beat valid.
- o_last  output  1  marks final beat of packet; qualified by o_valid.
- o_busy  output  1  high in SEND and DONE states.
- o_done  output  1  one-cycle pulse after packet completes.
- o_beat_cnt  output  LWIDTH  beats accepted in current/last packet.

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE; o_data=0, o_valid=0, o_last=0, o_busy=0, o_done=0, o_beat_cnt=0. Any in-flight packet is abandoned; no beat is emitted after rstn rises until a new i_start.
- Transfer: occurs at a posedge where o_valid=1 and i_ready=1.
- FSM states IDLE, SEND, DONE:
  - IDLE, i_start=1, i_len!=0: capture len and start value; o_data=i_start_val, o_valid=1, o_last=(i_len==1), o_beat_cnt=0; go to SEND. o_valid rises the cycle after i_start (latency 1).
  - IDLE, i_start=1, i_len==0: no beats; go to DONE.
  - SEND, transfer, not last: o_data<=o_data+1, modulo 2^DWIDTH (wraps 0xFF->0x00 at DWIDTH=8); o_beat_cnt++; o_last set when the next beat is the final one. o_valid stays 1, giving back-to-back beats at one per cycle.
  - SEND, transfer on o_last: o_valid<=0, o_last<=0, o_beat_cnt++; go to DONE.
  - SEND, no transfer: o_valid, o_data and o_last held stable. o_valid never drops without a transfer, and data never changes while unaccepted.
  - DONE: o_done=1 for exactly one cycle; return to IDLE.
- i_start is ignored in SEND and DONE (no queueing). The earliest restart is the first IDLE cycle after DONE.
- o_beat_cnt holds its value in IDLE until the next accepted start; it is cleared on that start.
- i_ready may toggle arbitrarily, including while o_valid=0; it has no effect when o_valid=0.

Optional Feature:
- Macro STREAM_PKT_TX_THROTTLE_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; reset seed 8'hA5) advances on every clock. Reset leaves it at the seed.
  - After a non-last transfer, if lfsr[0]=1, o_valid is driven 0 for exactly one cycle (gap state). The next beat is then presented with data already incremented.
  - Gaps occur only between beats, never while a beat is pending; the stability rule is unchanged.
  - Adds one internal GAP state; SEND->GAP->SEND.
- Undefined: no LFSR and no GAP state; beats are strictly back-to-back when i_ready=1.

Test Plan:
- Reset mid-packet: assert rstn=0 after 2 of 5 beats -> outputs 0 immediately (async); after release with no start, o_valid stays 0.
- Basic, no backpressure: i_ready=1, start val=0x10, len=4 -> o_valid high for 4 consecutive cycles starting 1 cycle after i_start. o_data 0x10,0x11,0x12,0x13; o_last only on 0x13; o_done pulse 1 cycle later; o_beat_cnt=4.
- Backpressure: val=0x20, len=3; i_ready low for 3 cycles while beat 0x21 is valid -> o_data holds 0x21 with o_valid=1 for all stalled cycles. Sink receives exactly 0x20,0x21,0x22 with no duplicates or drops.
- Wrap and zero length: val=0xFE, len=3 -> 0xFE,0xFF,0x00 with o_last on 0x00. Then len=0 -> no o_valid, o_done pulses 2 cycles after i_start, o_beat_cnt=0.
- Start while busy: second i_start (val=0x50) during SEND of a len=4 packet at 0x40 -> ignored; only 0x40-0x43 emitted. Start in first IDLE cycle after done -> accepted.
- With STREAM_PKT_TX_THROTTLE_EN, len=16, i_ready=1 -> 16 beats in order with ≥1 single-cycle gap. o_valid never falls while a beat is unaccepted; the count of gaps matches the LFSR reference model.
